// File: rtl/wb_mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter onto one Wishbone-classic memory bus.
// Optional ack timeout is compiled in with `define ARBITER_TIMEOUT_EN.
module wb_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction port (read only)
  input  logic                    i_stb_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic [DATA_WIDTH-1:0]   i_data_o,
  output logic                    i_ack_o,
  output logic                    i_err_o,
  // data port
  input  logic                    d_stb_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_sel_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_data_i,
  output logic [DATA_WIDTH-1:0]   d_data_o,
  output logic                    d_ack_o,
  output logic                    d_err_o,
  // shared memory bus
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_sel_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  input  logic [DATA_WIDTH-1:0]   m_data_i,
  input  logic                    m_ack_i,
  // arbiter state for observation
  output logic [1:0]              fsm_state
);

  // Handshake: a port raises stb with stable request fields and holds them until
  // its ack or err pulse; each grant yields exactly one bus cycle (cyc=stb) that
  // ends on the first m_ack_i (or timeout).

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`ifdef ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_d_q;
  logic            i_req, d_req, grant_i, grant_d, timeout;
  logic [CW-1:0]   to_cnt_q;
  logic            i_ack_q, d_ack_q, i_err_q, d_err_q, cyc_q;

  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A port still seeing its own completion pulse is masked so its held stb
  // is not mistaken for a fresh request.
  always_comb begin
    i_req   = i_stb_i & ~i_ack_q & ~i_err_q;
    d_req   = d_stb_i & ~d_ack_q & ~d_err_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    timeout = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || prio_d_q)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        timeout = TO_EN && !m_ack_i && (to_cnt_q == TO_LAST);
        if (m_ack_i || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_d_q <= 1'b1;
      cyc_q    <= 1'b0;
      m_we_o   <= 1'b0;
      m_sel_o  <= '0;
      m_addr_o <= '0;
      m_data_o <= '0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      i_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      i_data_o <= '0;
      d_data_o <= '0;
      to_cnt_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
      if (grant_i) begin
        cyc_q    <= 1'b1;
        m_we_o   <= 1'b0;
        m_sel_o  <= '1;
        m_addr_o <= i_addr_i;
        m_data_o <= '0;
        prio_d_q <= 1'b1;
        to_cnt_q <= '0;
      end
      if (grant_d) begin
        cyc_q    <= 1'b1;
        m_we_o   <= d_we_i;
        m_sel_o  <= d_sel_i;
        m_addr_o <= d_addr_i;
        m_data_o <= d_data_i;
        prio_d_q <= 1'b0;
        to_cnt_q <= '0;
      end
      if (state_q != IDLE) begin
        if (m_ack_i) begin
          cyc_q <= 1'b0;
          // A requester that walked away still lets the bus cycle finish, silently.
          if (state_q == BUSY_I && i_stb_i) begin
            i_ack_q  <= 1'b1;
            i_data_o <= m_data_i;
          end
          if (state_q == BUSY_D && d_stb_i) begin
            d_ack_q  <= 1'b1;
            d_data_o <= m_data_i;
          end
        end else if (timeout) begin
          cyc_q   <= 1'b0;
          i_err_q <= (state_q == BUSY_I);
          d_err_q <= (state_q == BUSY_D);
        end else begin
          to_cnt_q <= to_cnt_q + CW'(1);
        end
      end
    end
  end

  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;
  assign i_ack_o = i_ack_q;
  assign d_ack_o = d_ack_q;
  assign i_err_o = i_err_q;
  assign d_err_o = d_err_q;

endmodule
